// File: rtl/morse_stream_decoder.sv
// Morse key decoder: times presses and gaps in ticks,
// turns letters into 6-bit codes on a valid/ack port.
module morse_stream_decoder #(
  parameter int CNT_W      = 8,
  parameter int DASH_TICKS = 3,
  parameter int LETTER_GAP = 3,
  parameter int WORD_GAP   = 7,
  parameter int MAX_ELEM   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn,
  input  logic       ack,
  output logic [5:0] code,
  output logic       valid,
  output logic       overflow
);

  localparam int LW = $clog2(MAX_ELEM + 2);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] DT = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] LG = CNT_W'(LETTER_GAP);
  localparam logic [CNT_W-1:0] WG = CNT_W'(WORD_GAP);
  localparam logic [LW-1:0] LMAX = LW'(MAX_ELEM + 1);

  typedef enum logic [1:0] {
    IDLE, PRESS, GAP, WORD
  } state_t;

  state_t state, state_n;
  logic [CNT_W-1:0] press_cnt, press_n;
  logic [CNT_W-1:0] gap_cnt, gap_n, gap_inc;
  logic [MAX_ELEM-1:0] elems, elems_n;
  logic [LW-1:0] len, len_n;
  logic emit;
  logic [5:0] emit_code;
  logic [5:0] code_n;
  logic valid_n, ovf_n;

  // pattern p holds the first element in bit n-1
  function automatic logic [5:0] decode(
    input logic [LW-1:0] n,
    input logic [4:0] p
  );
    logic [5:0] c;
    c = 6'd63;
    case (n)
      LW'(1): c = p[0] ? 6'd20 : 6'd5;
      LW'(2): case (p[1:0])
        2'b00: c = 6'd9;
        2'b01: c = 6'd1;
        2'b10: c = 6'd14;
        default: c = 6'd13;
      endcase
      LW'(3): case (p[2:0])
        3'b000: c = 6'd19;
        3'b001: c = 6'd21;
        3'b010: c = 6'd18;
        3'b011: c = 6'd23;
        3'b100: c = 6'd4;
        3'b101: c = 6'd11;
        3'b110: c = 6'd7;
        default: c = 6'd15;
      endcase
      LW'(4): case (p[3:0])
        4'b0000: c = 6'd8;
        4'b0001: c = 6'd22;
        4'b0010: c = 6'd6;
        4'b0100: c = 6'd12;
        4'b0110: c = 6'd16;
        4'b0111: c = 6'd10;
        4'b1000: c = 6'd2;
        4'b1001: c = 6'd24;
        4'b1010: c = 6'd3;
        4'b1011: c = 6'd25;
        4'b1100: c = 6'd26;
        4'b1101: c = 6'd17;
        default: c = 6'd63;
      endcase
      LW'(5): case (p)
        5'b11111: c = 6'd27;
        5'b01111: c = 6'd28;
        5'b00111: c = 6'd29;
        5'b00011: c = 6'd30;
        5'b00001: c = 6'd31;
        5'b00000: c = 6'd32;
        5'b10000: c = 6'd33;
        5'b11000: c = 6'd34;
        5'b11100: c = 6'd35;
        5'b11110: c = 6'd36;
        default: c = 6'd63;
      endcase
      default: c = 6'd63;
    endcase
    return c;
  endfunction

  assign gap_inc = (gap_cnt == CMAX) ?
    gap_cnt : gap_cnt + CNT_W'(1);

  always_comb begin
    state_n   = state;
    press_n   = press_cnt;
    gap_n     = gap_cnt;
    elems_n   = elems;
    len_n     = len;
    emit      = 1'b0;
    emit_code = '0;
    unique case (state)
      IDLE: if (btn) begin
        state_n = PRESS;
        press_n = '0;
        elems_n = '0;
        len_n   = '0;
      end
      PRESS: if (!btn) begin
        elems_n = {elems[MAX_ELEM-2:0],
                   press_cnt >= DT};
        len_n   = (len == LMAX) ?
                  len : len + LW'(1);
        gap_n   = '0;
        state_n = GAP;
      end else if (tick && press_cnt != CMAX) begin
        press_n = press_cnt + CNT_W'(1);
      end
      GAP: if (btn) begin
        state_n = PRESS;
        press_n = '0;
      end else if (tick) begin
        gap_n = gap_inc;
        if (gap_inc == LG) begin
          emit      = 1'b1;
          emit_code = decode(len, elems[4:0]);
          state_n   = WORD;
        end
      end
      WORD: if (btn) begin
        state_n = PRESS;
        press_n = '0;
        elems_n = '0;
        len_n   = '0;
      end else if (tick) begin
        gap_n = gap_inc;
        if (gap_inc == WG) begin
          emit      = 1'b1;
          emit_code = 6'd37;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    code_n  = code;
    valid_n = valid;
    ovf_n   = overflow;
    unique case (1'b1)
      emit && !valid: begin
        code_n  = emit_code;
        valid_n = 1'b1;
      end
      emit && valid && ack: begin
        code_n = emit_code;
        ovf_n  = 1'b0;
      end
      emit && valid && !ack:
        ovf_n = 1'b1;
      !emit && valid && ack: begin
        code_n  = '0;
        valid_n = 1'b0;
        ovf_n   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      press_cnt <= '0;
      gap_cnt   <= '0;
      elems     <= '0;
      len       <= '0;
      code      <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      press_cnt <= press_n;
      gap_cnt   <= gap_n;
      elems     <= elems_n;
      len       <= len_n;
      code      <= code_n;
      valid     <= valid_n;
      overflow  <= ovf_n;
    end
  end

endmodule
